locked_reg_write_arbiter: RTL

- Shares the single user-locked configuration register between NUM_REQ requesters.
- Round-robin arbitrates write requests and checks each winner's user ID against the lock policy.
- Issues exactly one qualified write strobe per permitted request; returns a grant/error pulse to the requester.
- Sits between bus-side requesters and the locked register's data_in/usr_id/write inputs.

---
 rtl/locked_reg_write_arbiter_if.sv | 28 ++
 rtl/locked_reg_write_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/locked_reg_write_arbiter_if.sv
// Bus bundle between the write requesters and locked_reg_write_arbiter.
// The master side drives the request signals. The slave side is the arbiter,
// which drives the completion pulses and the write port of the locked register.
interface locked_reg_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic                       lock_en;
  logic [NUM_REQ-1:0]         req;
  logic [2*NUM_REQ-1:0]       req_id;
  logic [DATA_W*NUM_REQ-1:0]  req_data;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REQ-1:0]         err;
  logic                       reg_wr_en;
  logic [DATA_W-1:0]          reg_wr_data;
  logic [1:0]                 reg_usr_id;
  logic                       busy;

  modport master (
    output lock_en, req, req_id, req_data,
    input  gnt, err, reg_wr_en, reg_wr_data, reg_usr_id, busy
  );

  modport slave (
    input  lock_en, req, req_id, req_data,
    output gnt, err, reg_wr_en, reg_wr_data, reg_usr_id, busy
  );
endinterface

// File: rtl/locked_reg_write_arbiter.sv
// Round-robin arbiter in front of a single user-locked configuration register.
// Each winning request is checked against the lock policy (only OWNER_ID may
// write while lock_en is high). A permitted request produces one write strobe
// followed by a gnt pulse. A denied request produces gnt+err and no strobe.
// Optional build macro LOCKED_REG_VIOL_LOG_EN adds a saturating violation
// counter, the ID of the last violator and a sticky violation flag.
module locked_reg_write_arbiter #(
  parameter int         NUM_REQ  = 4,
  parameter int         DATA_W   = 8,
  parameter logic [1:0] OWNER_ID = 2'h2
) (
  input  logic clk,
  input  logic rst_n,
  locked_reg_write_arbiter_if.slave bus
`ifdef LOCKED_REG_VIOL_LOG_EN
  ,
  output logic [7:0] viol_count,
  output logic [1:0] last_viol_id,
  output logic       viol_flag
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      ptr, ptr_nxt;
  logic [PW-1:0]      win_sel;
  logic               found;
  logic               allowed;
  logic [NUM_REQ-1:0] win_oh;

  // Latched transaction (data only, no reset needed)
  logic [PW-1:0]      win_p0;
  logic [1:0]         id_p0;
  logic [DATA_W-1:0]  data_p0;

  // Registered outputs and their next values
  logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
  logic [NUM_REQ-1:0] err_q, err_nxt;
  logic               wr_en_q, wr_en_nxt;
  logic [DATA_W-1:0]  wr_data_q;
  logic [1:0]         usr_id_q;
  logic               busy_q;

`ifdef LOCKED_REG_VIOL_LOG_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  // Round-robin pick: first asserted request at or after ptr, wrapping
  always_comb begin
    int idx;
    idx     = 0;
    win_sel = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found   = 1'b1;
        win_sel = PW'(idx);
      end
    end
  end

  // Lock policy and one-hot form of the latched winner
  always_comb begin
    allowed         = !bus.lock_en || (id_p0 == OWNER_ID);
    win_oh          = '0;
    win_oh[win_p0]  = 1'b1;
  end

  // Next-state and next-output decode; outputs are registered so they line up with the state they belong to
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = '0;
    err_nxt   = '0;
    wr_en_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) state_nxt = CHECK;
      end
      CHECK: begin
        if (allowed) begin
          state_nxt = COMMIT;
          wr_en_nxt = 1'b1;
        end else begin
          state_nxt = RESP;
          gnt_nxt   = win_oh;
          err_nxt   = win_oh;
        end
      end
      COMMIT: begin
        state_nxt = RESP;
        gnt_nxt   = win_oh;
      end
      RESP: begin
        state_nxt = IDLE;
        ptr_nxt   = (int'(win_p0) == NUM_REQ - 1) ? '0 : win_p0 + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_q     <= '0;
      err_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      usr_id_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt_q   <= gnt_nxt;
      err_q   <= err_nxt;
      wr_en_q <= wr_en_nxt;
      busy_q  <= (state_nxt != IDLE);
      if (wr_en_nxt) begin
        wr_data_q <= data_p0;
        usr_id_q  <= id_p0;
      end
    end
  end

  // Capture the winner's index, ID and data when a request is accepted
  always_ff @(posedge clk) begin
    if (state == IDLE && found) begin
      win_p0  <= win_sel;
      id_p0   <= bus.req_id[2*int'(win_sel) +: 2];
      data_p0 <= bus.req_data[DATA_W*int'(win_sel) +: DATA_W];
    end
  end

`ifdef LOCKED_REG_VIOL_LOG_EN
  // Violation log, updated on every denied response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      viol_count   <= 8'h00;
      last_viol_id <= 2'h0;
      viol_flag    <= 1'b0;
    end else if (state == RESP && (|err_q)) begin
      viol_count   <= sat_inc8(viol_count);
      last_viol_id <= id_p0;
      viol_flag    <= 1'b1;
    end
  end
`endif

  assign bus.gnt         = gnt_q;
  assign bus.err         = err_q;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_wr_data = wr_data_q;
  assign bus.reg_usr_id  = usr_id_q;
  assign bus.busy        = busy_q;

endmodule
